// File: rtl/riscv_run_checker.sv
// riscv_run_checker: sequences DUT reset and run, stops on the halt instruction
// or when the cycle budget runs out, then freezes the core and compares
// register-file contents against an expectation table.
module riscv_run_checker #(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned NCHECK     = 16,
    parameter int unsigned RST_CYCLES = 2,
    parameter int unsigned MAX_CYCLES = 1024,
    parameter logic [31:0] HALT_INSN  = 32'h0000006F,
    parameter string       EFILE      = "expect.mem"
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [31:0]     instr,
    input  logic [XLEN-1:0] rf_rdata,
    output logic            dut_rst,
    output logic            dut_hold,
    output logic [4:0]      rf_raddr,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic            timeout,
    output logic [5:0]      fail_count,
    output logic [4:0]      first_fail_reg,
    output logic [XLEN-1:0] first_fail_got,
    output logic [31:0]     cycles
);

    localparam int unsigned EW = XLEN + 6;
    localparam int unsigned KW = (NCHECK > 1) ? $clog2(NCHECK) : 1;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_RESET = 3'd1;
    localparam logic [2:0] S_RUN   = 3'd2;
    localparam logic [2:0] S_CHECK = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    // Expectation table: {valid, reg, value}, entry 0 first.
    logic [EW-1:0] exp_mem [NCHECK];

    logic [2:0]      state, state_d;
    logic [31:0]     rst_cnt, rst_cnt_d;
    logic [KW-1:0]   k, k_d;
    logic [31:0]     cycles_d;
    logic            timeout_d, done_d, pass_d;
    logic [5:0]      fail_count_d;
    logic [4:0]      first_fail_reg_d;
    logic [XLEN-1:0] first_fail_got_d;
    logic            dut_rst_d, dut_hold_d, busy_d;

    logic [EW-1:0]   entry;
    logic            e_valid;
    logic [4:0]      e_reg;
    logic [XLEN-1:0] e_val;
    logic            mismatch;

    // Current table entry and its comparison against the DUT read port.
    always_comb begin
        entry    = exp_mem[k];
        e_valid  = entry[EW-1];
        e_reg    = entry[XLEN+4:XLEN];
        e_val    = entry[XLEN-1:0];
        mismatch = e_valid && (rf_rdata != e_val);
        rf_raddr = (state == S_CHECK) ? e_reg : 5'd0;
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d          = state;
        rst_cnt_d        = rst_cnt;
        k_d              = k;
        cycles_d         = cycles;
        timeout_d        = timeout;
        done_d           = done;
        pass_d           = pass;
        fail_count_d     = fail_count;
        first_fail_reg_d = first_fail_reg;
        first_fail_got_d = first_fail_got;

        case (state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d          = S_RESET;
                    rst_cnt_d        = 32'd0;
                    k_d              = '0;
                    cycles_d         = 32'd0;
                    timeout_d        = 1'b0;
                    done_d           = 1'b0;
                    pass_d           = 1'b0;
                    fail_count_d     = 6'd0;
                    first_fail_reg_d = 5'd0;
                    first_fail_got_d = '0;
                end
            end
            S_RESET: begin
                if (rst_cnt == 32'(RST_CYCLES - 1)) state_d = S_RUN;
                else                                 rst_cnt_d = rst_cnt + 32'd1;
            end
            S_RUN: begin
                // Halt wins over timeout and its cycle is not counted.
                if (instr == HALT_INSN) begin
                    state_d = S_CHECK;
                    k_d     = '0;
                end else begin
                    cycles_d = cycles + 32'd1;
                    if (cycles + 32'd1 == 32'(MAX_CYCLES)) begin
                        timeout_d = 1'b1;
                        state_d   = S_CHECK;
                        k_d       = '0;
                    end
                end
            end
            S_CHECK: begin
                if (mismatch) begin
                    if (fail_count == 6'd0) begin
                        first_fail_reg_d = e_reg;
                        first_fail_got_d = rf_rdata;
                    end
                    if (fail_count != 6'd63) fail_count_d = fail_count + 6'd1;
                end
                if (k == KW'(NCHECK - 1)) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                    pass_d  = (fail_count_d == 6'd0) && !timeout;
                end else begin
                    k_d = k + KW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        dut_rst_d  = (state_d == S_IDLE) || (state_d == S_RESET);
        dut_hold_d = (state_d == S_IDLE) || (state_d == S_CHECK) || (state_d == S_DONE);
        busy_d     = (state_d == S_RESET) || (state_d == S_RUN) || (state_d == S_CHECK);
    end

    // State and registered outputs, synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state          <= S_IDLE;
            rst_cnt        <= 32'd0;
            k              <= '0;
            cycles         <= 32'd0;
            timeout        <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
            fail_count     <= 6'd0;
            first_fail_reg <= 5'd0;
            first_fail_got <= '0;
            dut_rst        <= 1'b1;
            dut_hold       <= 1'b1;
            busy           <= 1'b0;
        end else begin
            state          <= state_d;
            rst_cnt        <= rst_cnt_d;
            k              <= k_d;
            cycles         <= cycles_d;
            timeout        <= timeout_d;
            done           <= done_d;
            pass           <= pass_d;
            fail_count     <= fail_count_d;
            first_fail_reg <= first_fail_reg_d;
            first_fail_got <= first_fail_got_d;
            dut_rst        <= dut_rst_d;
            dut_hold       <= dut_hold_d;
            busy           <= busy_d;
        end
    end

endmodule

// File: tb/tb_riscv_run_checker.sv
// Bench for riscv_run_checker: a toy core executes ADDI/SUB programs, a
// program-level reference model predicts the report, a monitor checks it.
module tb_riscv_run_checker;

    localparam int XLEN   = 32;
    localparam int NCHECK = 8;
    localparam int RSTC   = 2;
    localparam int MAXC   = 20;
    localparam logic [31:0] NOP = 32'h00000013;

    localparam logic [1:0] K_ADDI = 2'd0;
    localparam logic [1:0] K_SUB  = 2'd1;
    localparam logic [1:0] K_HALT = 2'd2;

    typedef struct packed {
        logic [1:0]  kind;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [11:0] imm;
    } op_t;

    typedef struct {
        int          fail_count;
        int          ff_reg;
        logic [31:0] ff_got;
        bit          timeout;
        bit          pass;
        int          cycles;
        int          latency;
        int          start_cyc;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            start = 1'b0;
    logic [31:0]     instr;
    logic [XLEN-1:0] rf_rdata;
    logic            dut_rst, dut_hold, busy, done, pass, timeout;
    logic [4:0]      rf_raddr, first_fail_reg;
    logic [5:0]      fail_count;
    logic [XLEN-1:0] first_fail_got;
    logic [31:0]     cycles;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    op_t         ops [64];
    int          nops;
    logic [31:0] prog [64];
    bit          tbl_valid [NCHECK];
    logic [4:0]  tbl_reg   [NCHECK];
    logic [31:0] tbl_val   [NCHECK];
    logic [31:0] fin_regs  [32];
    int          m_n;
    bit          m_halted;
    exp_t        sb_q [$];

    // toy core state
    int          pc;
    logic [31:0] regs [32];

    riscv_run_checker #(
        .XLEN(XLEN), .NCHECK(NCHECK), .RST_CYCLES(RSTC), .MAX_CYCLES(MAXC),
        .HALT_INSN(32'h0000006F), .EFILE("")
    ) dut (
        .clk(clk), .rst(rst), .start(start), .instr(instr), .rf_rdata(rf_rdata),
        .dut_rst(dut_rst), .dut_hold(dut_hold), .rf_raddr(rf_raddr), .busy(busy),
        .done(done), .pass(pass), .timeout(timeout), .fail_count(fail_count),
        .first_fail_reg(first_fail_reg), .first_fail_got(first_fail_got), .cycles(cycles)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    assign instr    = (pc < 64) ? prog[pc] : NOP;
    assign rf_rdata = regs[rf_raddr];

    // Toy single-cycle core gated by the checker's reset and hold.
    always @(posedge clk) begin
        if (dut_rst) begin
            pc <= 0;
            for (int i = 0; i < 32; i++) regs[i] <= 32'd0;
        end else if (!dut_hold) begin
            case (instr[6:0])
                7'h13: begin
                    if (instr[11:7] != 5'd0)
                        regs[instr[11:7]] <= regs[instr[19:15]] + {{20{instr[31]}}, instr[31:20]};
                    pc <= pc + 1;
                end
                7'h33: begin
                    if (instr[11:7] != 5'd0)
                        regs[instr[11:7]] <= (instr[31:25] == 7'h20)
                            ? regs[instr[19:15]] - regs[instr[24:20]]
                            : regs[instr[19:15]] + regs[instr[24:20]];
                    pc <= pc + 1;
                end
                default: ;
            endcase
        end
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Monitor: every rising done is matched against the oldest expected report.
    logic done_q = 1'b0;
    always @(negedge clk) begin
        if (done && !done_q) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_done", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("fail_count", 64'(fail_count), 64'(e.fail_count));
                chk("first_fail_reg", 64'(first_fail_reg), 64'(e.ff_reg));
                chk("first_fail_got", 64'(first_fail_got), 64'(e.ff_got));
                chk("timeout", 64'(timeout), 64'(e.timeout));
                chk("pass", 64'(pass), 64'(e.pass));
                chk("cycles", 64'(cycles), 64'(e.cycles));
                chk("latency", 64'(cyc - e.start_cyc), 64'(e.latency));
            end
        end
        done_q <= done;
    end

    task automatic clear_prog();
        nops = 0;
        for (int i = 0; i < NCHECK; i++) begin
            tbl_valid[i] = 1'b0;
            tbl_reg[i]   = 5'd0;
            tbl_val[i]   = 32'd0;
        end
    endtask

    task automatic add_op(input logic [1:0] kind, input int rd, input int rs1, input int rs2, input int imm);
        op_t o;
        o.kind = kind; o.rd = 5'(rd); o.rs1 = 5'(rs1); o.rs2 = 5'(rs2); o.imm = 12'(imm);
        ops[nops] = o;
        nops++;
    endtask

    task automatic set_tbl(input int i, input bit v, input int r, input logic [31:0] val);
        tbl_valid[i] = v; tbl_reg[i] = 5'(r); tbl_val[i] = val;
    endtask

    // Program-level reference: what the register file holds when the run ends.
    task automatic ref_exec();
        for (int i = 0; i < 32; i++) fin_regs[i] = 32'd0;
        m_n = 0;
        m_halted = 1'b0;
        for (int i = 0; i < MAXC; i++) begin
            if (i < nops && ops[i].kind == K_HALT) begin
                m_halted = 1'b1;
                break;
            end
            if (i < nops && ops[i].rd != 5'd0) begin
                if (ops[i].kind == K_ADDI)
                    fin_regs[ops[i].rd] = fin_regs[ops[i].rs1] + {{20{ops[i].imm[11]}}, ops[i].imm};
                else
                    fin_regs[ops[i].rd] = fin_regs[ops[i].rs1] - fin_regs[ops[i].rs2];
            end
            m_n++;
        end
    endtask

    function automatic exp_t expect_result();
        exp_t e;
        e.fail_count = 0; e.ff_reg = 0; e.ff_got = 32'd0; e.start_cyc = 0;
        for (int i = 0; i < NCHECK; i++) begin
            if (tbl_valid[i] && fin_regs[tbl_reg[i]] != tbl_val[i]) begin
                if (e.fail_count == 0) begin
                    e.ff_reg = int'(tbl_reg[i]);
                    e.ff_got = fin_regs[tbl_reg[i]];
                end
                if (e.fail_count < 63) e.fail_count++;
            end
        end
        e.timeout = !m_halted;
        e.cycles  = m_n;
        e.pass    = (e.fail_count == 0) && m_halted;
        e.latency = 1 + RSTC + m_n + (m_halted ? 1 : 0) + NCHECK;
        return e;
    endfunction

    // Encode program into the core's memory and the table into the checker.
    task automatic load_all();
        for (int i = 0; i < 64; i++) begin
            if (i >= nops)                  prog[i] = NOP;
            else if (ops[i].kind == K_HALT) prog[i] = 32'h0000006F;
            else if (ops[i].kind == K_ADDI) prog[i] = {ops[i].imm, ops[i].rs1, 3'b000, ops[i].rd, 7'h13};
            else prog[i] = {7'h20, ops[i].rs2, ops[i].rs1, 3'b000, ops[i].rd, 7'h33};
        end
        for (int i = 0; i < NCHECK; i++) dut.exp_mem[i] = {tbl_valid[i], tbl_reg[i], tbl_val[i]};
    endtask

    task automatic do_run(input bit push, input bit noise);
        exp_t e;
        bit got_done;
        load_all();
        ref_exec();
        e = expect_result();
        @(negedge clk);
        start = 1'b1;
        e.start_cyc = cyc;
        if (push) sb_q.push_back(e);
        @(negedge clk);
        start = 1'b0;
        chk("done_low_after_start", 64'(done), 64'd0);
        chk("busy_after_start", 64'(busy), 64'd1);
        got_done = 1'b0;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            if (done) begin
                got_done = 1'b1;
                break;
            end
            start = (noise && busy) ? ($urandom_range(0, 3) == 0) : 1'b0;
        end
        start = 1'b0;
        chk("done_seen", 64'(got_done), 64'd1);
        @(negedge clk);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_dut_rst"}, 64'(dut_rst), 64'd1);
        chk({tag, "_dut_hold"}, 64'(dut_hold), 64'd1);
        chk({tag, "_rf_raddr"}, 64'(rf_raddr), 64'd0);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_done"}, 64'(done), 64'd0);
        chk({tag, "_pass"}, 64'(pass), 64'd0);
        chk({tag, "_timeout"}, 64'(timeout), 64'd0);
        chk({tag, "_fail_count"}, 64'(fail_count), 64'd0);
        chk({tag, "_ff_reg"}, 64'(first_fail_reg), 64'd0);
        chk({tag, "_ff_got"}, 64'(first_fail_got), 64'd0);
        chk({tag, "_cycles"}, 64'(cycles), 64'd0);
    endtask

    task automatic basic_prog();
        clear_prog();
        add_op(K_ADDI, 1, 0, 0, 10);
        add_op(K_ADDI, 2, 0, 0, 5);
        add_op(K_SUB,  6, 1, 2, 0);
        add_op(K_HALT, 0, 0, 0, 0);
        set_tbl(0, 1'b1, 1, 32'hA);
        set_tbl(1, 1'b1, 2, 32'h5);
        set_tbl(2, 1'b1, 6, 32'h5);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) prog[i] = NOP;
        clear_prog();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_vals("reset");
        rst = 1'b1;
        @(negedge clk);

        // pass case, then single mismatch on x6
        basic_prog();
        do_run(1'b1, 1'b0);
        set_tbl(2, 1'b1, 6, 32'h6);
        do_run(1'b1, 1'b0);

        // no halt: budget runs out, table still checked
        clear_prog();
        for (int i = 0; i < 25; i++) add_op(K_ADDI, 1, 1, 0, 1);
        set_tbl(0, 1'b1, 1, 32'd20);
        set_tbl(3, 1'b1, 0, 32'd0);
        do_run(1'b1, 1'b1);

        // reference table with invalid entries interleaved
        clear_prog();
        add_op(K_ADDI, 5, 0, 0, 15);
        add_op(K_ADDI, 9, 0, 0, 250);
        add_op(K_ADDI, 12, 0, 0, -3);
        add_op(K_ADDI, 13, 0, 0, 1);
        add_op(K_ADDI, 14, 0, 0, 0);
        add_op(K_HALT, 0, 0, 0, 0);
        set_tbl(0, 1'b1, 5, 32'd15);
        set_tbl(1, 1'b0, 5, 32'hDEAD);
        set_tbl(2, 1'b1, 9, 32'hFA);
        set_tbl(3, 1'b0, 9, 32'h1);
        set_tbl(4, 1'b1, 12, 32'hFFFFFFFD);
        set_tbl(5, 1'b1, 13, 32'd1);
        set_tbl(6, 1'b0, 0, 32'h7);
        set_tbl(7, 1'b1, 14, 32'd0);
        do_run(1'b1, 1'b1);

        // abort mid-RUN, then rerun the same program
        basic_prog();
        load_all();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("abort_busy", 64'(busy), 64'd1);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        check_reset_vals("abort");
        repeat (3) @(negedge clk);
        chk("abort_no_done", 64'(done), 64'd0);
        do_run(1'b1, 1'b0);

        // randomized programs and tables, some with start noise
        for (int r = 0; r < 14; r++) begin
            int hpos;
            clear_prog();
            nops = 0;
            hpos = int'($urandom_range(0, 30));
            for (int i = 0; i < int'($urandom_range(0, 26)); i++) begin
                if (i == hpos) add_op(K_HALT, 0, 0, 0, 0);
                else if ($urandom_range(0, 2) == 0)
                    add_op(K_SUB, int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                           int'($urandom_range(0, 15)), 0);
                else
                    add_op(K_ADDI, int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), 0,
                           int'($urandom_range(0, 4095)));
            end
            ref_exec();
            for (int i = 0; i < NCHECK; i++) begin
                int rr;
                rr = int'($urandom_range(0, 15));
                set_tbl(i, $urandom_range(0, 3) != 0, rr,
                        ($urandom_range(0, 1) == 0) ? fin_regs[rr] : $urandom());
            end
            do_run(1'b1, r[0]);
        end

        repeat (5) @(negedge clk);
        chk("scoreboard_empty", 64'(sb_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global time bound so the bench always terminates.
    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
